// File: rtl/mac_nm_pkg.sv
// Shared widths, instruction bit positions, load-state encoding and slicing
// helpers for the N:M sparse MAC tile.
package mac_nm_pkg;

  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int GRP_DEF     = 4;
  localparam int NNZ_DEF     = 2;

  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;
  localparam int INST_CLR  = 2;
  localparam int INST_W    = 3;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } load_state_e;

  // Low bit of field k in a vector of equal-width packed fields.
  function automatic int lane_lo(input int k, input int width);
    return k * width;
  endfunction

  function automatic int lane_hi(input int k, input int width);
    return (k + 1) * width - 1;
  endfunction

endpackage

// File: rtl/mac_nm.sv
// Combinational N:M sparse dot product: gathers the indexed activations,
// multiplies them by signed weights and adds them onto the incoming psum.
module mac_nm
  import mac_nm_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int GRP     = GRP_DEF,
  parameter int NNZ     = NNZ_DEF,
  parameter int IDX_BW  = $clog2(GRP)
) (
  input  logic [bw*GRP-1:0]     act,
  input  logic [bw*NNZ-1:0]     w,
  input  logic [IDX_BW*NNZ-1:0] idx,
  input  logic [psum_bw-1:0]    psum_in,
  output logic [psum_bw-1:0]    psum_out
);

  logic [bw-1:0]      act_lane [GRP];
  logic [psum_bw-1:0] prod_ext [NNZ];
  logic [psum_bw-1:0] part     [NNZ+1];

  genvar gi;

  generate
    for (gi = 0; gi < GRP; gi++) begin : g_lane
      assign act_lane[gi] = act[lane_lo(gi, bw) +: bw];
    end

    for (gi = 0; gi < NNZ; gi++) begin : g_slot
      logic [IDX_BW-1:0]    sel;
      logic signed [bw:0]   act_s;
      logic signed [bw-1:0] w_s;
      logic signed [2*bw:0] prod;

      assign sel   = idx[lane_lo(gi, IDX_BW) +: IDX_BW];
      // Activations are unsigned: a zero MSB keeps them positive in the signed multiply.
      assign act_s = signed'({1'b0, act_lane[sel]});
      assign w_s   = signed'(w[lane_lo(gi, bw) +: bw]);
      assign prod  = (2*bw+1)'(act_s) * (2*bw+1)'(w_s);
      assign prod_ext[gi] = psum_bw'(prod);
    end

    assign part[0] = psum_in;
    for (gi = 0; gi < NNZ; gi++) begin : g_sum
      assign part[gi+1] = part[gi] + prod_ext[gi];
    end
  endgenerate

  assign psum_out = part[NNZ];

endmodule

// File: rtl/mac_tile_nm.sv
// Weight-stationary systolic MAC tile with N:M sparse weights, a two-state
// load FSM that absorbs the first load token, and a kernel-clear path.
module mac_tile_nm
  import mac_nm_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int GRP     = GRP_DEF,
  parameter int NNZ     = NNZ_DEF,
  parameter int IDX_BW  = $clog2(GRP)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [bw*GRP-1:0]     in_w,
  output logic [bw*GRP-1:0]     out_e,
  input  logic [IDX_BW*NNZ-1:0] idx_w,
  output logic [IDX_BW*NNZ-1:0] idx_e,
  input  logic [INST_W-1:0]     inst_w,
  output logic [INST_W-1:0]     inst_e,
  input  logic [psum_bw-1:0]    in_n,
  output logic [psum_bw-1:0]    out_s
);

  logic [bw*NNZ-1:0]     w_reg;
  logic [IDX_BW*NNZ-1:0] idx_reg;
  load_state_e           state_reg, state_next;
  logic                  load_ready;
  logic                  capture;
  logic                  fwd_load;
  logic [psum_bw-1:0]    psum_next;

  logic ld, ex, clr;
  assign ld  = inst_w[INST_LOAD];
  assign ex  = inst_w[INST_EXEC];
  assign clr = inst_w[INST_CLR];

  always_comb begin
    state_next = state_reg;
    load_ready = 1'b0;
    capture    = 1'b0;
    fwd_load   = 1'b0;
    unique case (state_reg)
      ST_EMPTY: begin
        load_ready = 1'b1;
        // Clear beats a simultaneous load: the token is dropped, not stored.
        if (ld && !clr) begin
          capture    = 1'b1;
          state_next = ST_LOADED;
        end
      end
      ST_LOADED: begin
        fwd_load = ld && !clr;
        if (clr) state_next = ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_EMPTY;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_reg   <= '0;
      idx_reg <= '0;
    end else if (clr) begin
      w_reg   <= '0;
      idx_reg <= '0;
    end else if (capture) begin
      w_reg   <= in_w[bw*NNZ-1:0];
      idx_reg <= idx_w;
    end
  end

  // Uses the registered weights, so an execute coinciding with a clear or
  // a load still sees the weights from before that edge.
  mac_nm #(
    .bw     (bw),
    .psum_bw(psum_bw),
    .GRP    (GRP),
    .NNZ    (NNZ),
    .IDX_BW (IDX_BW)
  ) u_mac (
    .act     (in_w),
    .w       (w_reg),
    .idx     (idx_reg),
    .psum_in (in_n),
    .psum_out(psum_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_e  <= '0;
      idx_e  <= '0;
      inst_e <= '0;
      out_s  <= '0;
    end else begin
      if (ex || ld) begin
        out_e <= in_w;
        idx_e <= idx_w;
      end
      inst_e[INST_LOAD] <= fwd_load;
      inst_e[INST_EXEC] <= ex;
      inst_e[INST_CLR]  <= clr;
      if (ex) out_s <= psum_next;
    end
  end

endmodule

// File: tb/tb_mac_tile_nm.sv
// Directed test of mac_tile_nm: load absorb/forward, sparse execute, wrap,
// clear priority, simultaneous events and asynchronous reset.
module tb_mac_tile_nm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_w;
  logic [15:0] out_e;
  logic [3:0]  idx_w;
  logic [3:0]  idx_e;
  logic [2:0]  inst_w;
  logic [2:0]  inst_e;
  logic [15:0] in_n;
  logic [15:0] out_s;

  int n_checks = 0;
  int n_fail   = 0;

  mac_tile_nm dut (
    .clk   (clk),
    .reset (reset),
    .in_w  (in_w),
    .out_e (out_e),
    .idx_w (idx_w),
    .idx_e (idx_e),
    .inst_w(inst_w),
    .inst_e(inst_e),
    .in_n  (in_n),
    .out_s (out_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    in_w   = '0;
    idx_w  = '0;
    inst_w = '0;
    in_n   = '0;

    // Reset then idle
    step();
    step();
    check("rst_out_s_held", 32'(out_s), 32'h0);
    reset = 1'b1;
    step();
    check("rst_out_s", 32'(out_s), 32'h0);
    check("rst_inst_e", 32'(inst_e), 32'h0);
    check("rst_out_e", 32'(out_e), 32'h0);
    check("rst_idx_e", 32'(idx_e), 32'h0);
    check("rst_load_ready", 32'(dut.load_ready), 32'h1);

    // Load absorb: w0=3, w1=-2, idx0=1, idx1=3
    inst_w = 3'b001;
    in_w   = 16'h00E3;
    idx_w  = 4'b1101;
    step();
    check("ld1_inst_e", 32'(inst_e), 32'h0);
    check("ld1_load_ready", 32'(dut.load_ready), 32'h0);
    check("ld1_out_e", 32'(out_e), 32'h00E3);
    check("ld1_idx_e", 32'(idx_e), 32'hD);
    step();
    check("ld2_inst_e", 32'(inst_e), 32'h1);

    // Execute: 10 + 3*a1 + (-2)*a3 = 10 + 6 - 10 = 6
    inst_w = 3'b010;
    in_w   = 16'h5729;
    idx_w  = 4'b0000;
    in_n   = 16'd10;
    step();
    check("exec_out_s", 32'(out_s), 32'h6);
    check("exec_inst_e", 32'(inst_e), 32'h2);
    check("exec_out_e", 32'(out_e), 32'h5729);

    // Idle: out_s and out_e hold
    inst_w = 3'b000;
    in_w   = 16'hAAAA;
    in_n   = 16'd99;
    step();
    check("idle_out_s", 32'(out_s), 32'h6);
    check("idle_out_e", 32'(out_e), 32'h5729);

    // Clear alone
    inst_w = 3'b100;
    step();
    check("clr_load_ready", 32'(dut.load_ready), 32'h1);
    check("clr_inst_e", 32'(inst_e), 32'h4);

    // Wrap with duplicate indices: 0xFFF0 + 2*7*15 = 0x100C2
    inst_w = 3'b001;
    in_w   = 16'h0077;
    idx_w  = 4'b1010;
    step();
    inst_w = 3'b010;
    in_w   = 16'h0F00;
    in_n   = 16'hFFF0;
    step();
    check("wrap_out_s", 32'(out_s), 32'h00C2);

    // Clear together with load while LOADED: clear wins
    inst_w = 3'b101;
    in_w   = 16'h0011;
    idx_w  = 4'b0000;
    step();
    check("clrld_load_ready", 32'(dut.load_ready), 32'h1);
    check("clrld_inst_e", 32'(inst_e), 32'h4);
    inst_w = 3'b010;
    in_w   = 16'hFFFF;
    in_n   = 16'd5;
    step();
    check("clrld_exec", 32'(out_s), 32'h5);

    // Subsequent load captured: w0=1, w1=-1, idx0=0, idx1=1
    inst_w = 3'b001;
    in_w   = 16'h00F1;
    idx_w  = 4'b0100;
    step();
    check("reld_load_ready", 32'(dut.load_ready), 32'h0);
    inst_w = 3'b010;
    in_w   = 16'h0064;
    in_n   = 16'd100;
    step();
    check("reld_exec", 32'(out_s), 32'd98);

    // Clear together with execute: pre-clear weights, 0 + 4 - 6 = -2
    inst_w = 3'b110;
    in_n   = 16'd0;
    step();
    check("clrex_out_s", 32'(out_s), 32'hFFFE);
    check("clrex_load_ready", 32'(dut.load_ready), 32'h1);
    inst_w = 3'b010;
    in_n   = 16'd7;
    step();
    check("clrex_after", 32'(out_s), 32'h7);

    // Load together with execute while EMPTY: old zero weights used
    inst_w = 3'b011;
    in_w   = 16'h0022;
    idx_w  = 4'b0000;
    in_n   = 16'd3;
    step();
    check("ldex_out_s", 32'(out_s), 32'h3);
    check("ldex_inst_e", 32'(inst_e), 32'h2);
    check("ldex_load_ready", 32'(dut.load_ready), 32'h0);
    inst_w = 3'b010;
    in_w   = 16'h0005;
    in_n   = 16'd0;
    step();
    check("ldex_after", 32'(out_s), 32'd20);

    // Asynchronous reset between edges while executing
    in_n = 16'd50;
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_s", 32'(out_s), 32'h0);
    check("arst_inst_e", 32'(inst_e), 32'h0);
    check("arst_load_ready", 32'(dut.load_ready), 32'h1);
    #2;
    reset  = 1'b1;
    inst_w = 3'b010;
    in_w   = 16'h0005;
    in_n   = 16'h1234;
    step();
    check("arst_exec", 32'(out_s), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
